// File: rtl/ae_luma_stat_5x5.sv
// ae_luma_stat_5x5: reduces each 5x5 luma window to a box-filtered 8-bit value
// over a 3-stage pipeline, accumulates per-frame statistics, and divides out the
// frame mean after vsync falls so the AE loop gets a single valid strobe.
module ae_luma_stat_5x5 #(
  parameter logic [7:0] HI_THR = 8'd235,
  parameter logic [7:0] LO_THR = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        matrix_frame_vsync,
  input  logic        matrix_frame_href,
  input  logic        matrix_frame_hsync,
  input  logic [10:0] matrix_p11, matrix_p12, matrix_p13, matrix_p14, matrix_p15,
  input  logic [10:0] matrix_p21, matrix_p22, matrix_p23, matrix_p24, matrix_p25,
  input  logic [10:0] matrix_p31, matrix_p32, matrix_p33, matrix_p34, matrix_p35,
  input  logic [10:0] matrix_p41, matrix_p42, matrix_p43, matrix_p44, matrix_p45,
  input  logic [10:0] matrix_p51, matrix_p52, matrix_p53, matrix_p54, matrix_p55,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_hsync,
  output logic [7:0]  post_img_Y,
  output logic [7:0]  frame_mean,
  output logic [23:0] frame_pix_cnt,
  output logic [23:0] frame_hi_cnt,
  output logic [23:0] frame_lo_cnt,
  output logic        frame_stat_valid
);

  localparam logic [23:0] CNT_MAX = 24'hFFFFFF;

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  logic [13:0] row1_d, row2_d, row3_d, row4_d, row5_d;
  logic [13:0] row1_q, row2_q, row3_q, row4_q, row5_q;
  logic [2:0]  sync1_q, sync2_q, sync3_q;
  logic [15:0] total_d, total_q;
  logic [11:0] yRaw_d;
  logic [7:0]  ySat_d, y_q;

  logic [31:0] sum_acc_q;
  logic [23:0] cnt_acc_q, hi_acc_q, lo_acc_q;
  logic        prev_vsync_q;
  logic        frameEdge;

  state_t      state_q, state_d;
  logic [4:0]  iter_q;
  logic [31:0] dvd_q;
  logic [23:0] rem_q;
  logic [23:0] snap_cnt_q, snap_hi_q, snap_lo_q;
  logic [24:0] shifted_d;
  logic [23:0] diff_d, rem_d;
  logic        qbit_d;

  logic        doneLoad;
  logic [7:0]  meanNew;
  logic [7:0]  mean_q;
  logic [23:0] pix_q, hi_q, lo_q;

  // Stage 1/2 arithmetic: five 14-bit row sums, then their 16-bit total
  always_comb begin
    row1_d  = 14'(matrix_p11) + 14'(matrix_p12) + 14'(matrix_p13) + 14'(matrix_p14) + 14'(matrix_p15);
    row2_d  = 14'(matrix_p21) + 14'(matrix_p22) + 14'(matrix_p23) + 14'(matrix_p24) + 14'(matrix_p25);
    row3_d  = 14'(matrix_p31) + 14'(matrix_p32) + 14'(matrix_p33) + 14'(matrix_p34) + 14'(matrix_p35);
    row4_d  = 14'(matrix_p41) + 14'(matrix_p42) + 14'(matrix_p43) + 14'(matrix_p44) + 14'(matrix_p45);
    row5_d  = 14'(matrix_p51) + 14'(matrix_p52) + 14'(matrix_p53) + 14'(matrix_p54) + 14'(matrix_p55);
    total_d = 16'(row1_q) + 16'(row2_q) + 16'(row3_q) + 16'(row4_q) + 16'(row5_q);
  end

  // Stage 3 arithmetic: multiply by 41/1024 (about 1/25) and clamp to 8 bits
  always_comb begin
    yRaw_d = 12'(({6'd0, total_q} * 22'd41) >> 10);
    ySat_d = (|yRaw_d[11:8]) ? 8'd255 : yRaw_d[7:0];
  end

  // Pixel pipeline registers with the syncs travelling alongside
  always_ff @(posedge clk) begin
    if (rst) begin
      row1_q  <= '0; row2_q <= '0; row3_q <= '0; row4_q <= '0; row5_q <= '0;
      total_q <= '0;
      y_q     <= '0;
      sync1_q <= '0; sync2_q <= '0; sync3_q <= '0;
    end else begin
      row1_q  <= row1_d; row2_q <= row2_d; row3_q <= row3_d;
      row4_q  <= row4_d; row5_q <= row5_d;
      sync1_q <= {matrix_frame_vsync, matrix_frame_href, matrix_frame_hsync};
      total_q <= total_d;
      sync2_q <= sync1_q;
      y_q     <= sync2_q[1] ? ySat_d : 8'd0;
      sync3_q <= sync2_q;
    end
  end

  assign post_frame_vsync = sync3_q[2];
  assign post_frame_href  = sync3_q[1];
  assign post_frame_hsync = sync3_q[0];
  assign post_img_Y       = y_q;

  // The frame ends on the first cycle the retimed vsync is seen low after high
  assign frameEdge = prev_vsync_q & ~post_frame_vsync;

  // Frame accumulators, held clear outside the active vsync window
  always_ff @(posedge clk) begin
    if (rst || !post_frame_vsync) begin
      sum_acc_q <= '0;
      cnt_acc_q <= '0;
      hi_acc_q  <= '0;
      lo_acc_q  <= '0;
    end else if (post_frame_href) begin
      sum_acc_q <= sum_acc_q + {24'd0, y_q};
      if (cnt_acc_q != CNT_MAX) cnt_acc_q <= cnt_acc_q + 24'd1;
      if (y_q >= HI_THR && hi_acc_q != CNT_MAX) hi_acc_q <= hi_acc_q + 24'd1;
      if (y_q <= LO_THR && lo_acc_q != CNT_MAX) lo_acc_q <= lo_acc_q + 24'd1;
    end
  end

  // Previous retimed vsync for edge detection
  always_ff @(posedge clk) begin
    if (rst) prev_vsync_q <= 1'b0;
    else     prev_vsync_q <= post_frame_vsync;
  end

  // Control: any frame edge (re)starts the divide, otherwise step IDLE->DIV->DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      DIV:     state_d = (iter_q == 5'd31) ? DONE : DIV;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frameEdge) state_d = DIV;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // One restoring-division step; a zero count never produces quotient bits
  always_comb begin
    shifted_d = {rem_q, dvd_q[31]};
    diff_d    = shifted_d[23:0] - snap_cnt_q;
    qbit_d    = (snap_cnt_q != 24'd0) && (shifted_d >= {1'b0, snap_cnt_q});
    rem_d     = qbit_d ? diff_d : shifted_d[23:0];
  end

  // Snapshot on the frame edge, then shift one quotient bit in per DIV cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q      <= '0;
      rem_q      <= '0;
      iter_q     <= '0;
      snap_cnt_q <= '0;
      snap_hi_q  <= '0;
      snap_lo_q  <= '0;
    end else if (frameEdge) begin
      dvd_q      <= sum_acc_q;
      rem_q      <= '0;
      iter_q     <= '0;
      snap_cnt_q <= cnt_acc_q;
      snap_hi_q  <= hi_acc_q;
      snap_lo_q  <= lo_acc_q;
    end else if (state_q == DIV) begin
      dvd_q  <= {dvd_q[30:0], qbit_d};
      rem_q  <= rem_d;
      iter_q <= iter_q + 5'd1;
    end
  end

  // DONE presents the fresh result unless a new edge aborts it in that cycle
  always_comb begin
    doneLoad = (state_q == DONE) && !frameEdge;
    if (snap_cnt_q == 24'd0) meanNew = 8'd0;
    else if (|dvd_q[31:8])   meanNew = 8'd255;
    else                     meanNew = dvd_q[7:0];
  end

  // Held frame results, refreshed only by a completed DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      mean_q <= '0;
      pix_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (doneLoad) begin
      mean_q <= meanNew;
      pix_q  <= snap_cnt_q;
      hi_q   <= snap_hi_q;
      lo_q   <= snap_lo_q;
    end
  end

  assign frame_stat_valid = doneLoad;
  assign frame_mean       = doneLoad ? meanNew    : mean_q;
  assign frame_pix_cnt    = doneLoad ? snap_cnt_q : pix_q;
  assign frame_hi_cnt     = doneLoad ? snap_hi_q  : hi_q;
  assign frame_lo_cnt     = doneLoad ? snap_lo_q  : lo_q;

endmodule

// File: tb/tb_ae_luma_stat_5x5.sv
// Testbench for ae_luma_stat_5x5: directed frames plus randomized windows,
// checked every cycle against a behavioural model of the filter and frame stats.
module tb_ae_luma_stat_5x5;

  typedef struct packed {
    logic       v;
    logic       h;
    logic       hs;
    logic [7:0] y;
  } pix_t;

  logic        clk;
  logic        rst;
  logic        matrix_frame_vsync, matrix_frame_href, matrix_frame_hsync;
  logic [10:0] tap [25];
  logic        post_frame_vsync, post_frame_href, post_frame_hsync;
  logic [7:0]  post_img_Y;
  logic [7:0]  frame_mean;
  logic [23:0] frame_pix_cnt, frame_hi_cnt, frame_lo_cnt;
  logic        frame_stat_valid;

  int checks;
  int failures;
  int stepIdx;

  // Model state: expected pixel stream, accumulators, pending result and held outputs
  pix_t        expQ [$];
  logic        prevV;
  longint      aSum, pSum;
  int          aCnt, aHi, aLo, pCnt, pHi, pLo;
  logic        pend;
  int          deadline;
  int          lastEdge;
  logic        edgeFlag;
  logic [7:0]  heldMean;
  logic [23:0] heldCnt, heldHi, heldLo;
  logic        validSeen;
  int          validStep;
  int          validCount;

  ae_luma_stat_5x5 dut (
    .clk(clk), .rst(rst),
    .matrix_frame_vsync(matrix_frame_vsync),
    .matrix_frame_href(matrix_frame_href),
    .matrix_frame_hsync(matrix_frame_hsync),
    .matrix_p11(tap[0]),  .matrix_p12(tap[1]),  .matrix_p13(tap[2]),  .matrix_p14(tap[3]),  .matrix_p15(tap[4]),
    .matrix_p21(tap[5]),  .matrix_p22(tap[6]),  .matrix_p23(tap[7]),  .matrix_p24(tap[8]),  .matrix_p25(tap[9]),
    .matrix_p31(tap[10]), .matrix_p32(tap[11]), .matrix_p33(tap[12]), .matrix_p34(tap[13]), .matrix_p35(tap[14]),
    .matrix_p41(tap[15]), .matrix_p42(tap[16]), .matrix_p43(tap[17]), .matrix_p44(tap[18]), .matrix_p45(tap[19]),
    .matrix_p51(tap[20]), .matrix_p52(tap[21]), .matrix_p53(tap[22]), .matrix_p54(tap[23]), .matrix_p55(tap[24]),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href(post_frame_href),
    .post_frame_hsync(post_frame_hsync),
    .post_img_Y(post_img_Y),
    .frame_mean(frame_mean),
    .frame_pix_cnt(frame_pix_cnt),
    .frame_hi_cnt(frame_hi_cnt),
    .frame_lo_cnt(frame_lo_cnt),
    .frame_stat_valid(frame_stat_valid)
  );

  // Free-running pixel clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Model reset: pipeline starts as zeros, no frame pending, results cleared
  task automatic modelInit();
    pix_t z;
    z = '0;
    expQ.delete();
    repeat (3) expQ.push_back(z);
    prevV = 1'b0;
    aSum = 0; aCnt = 0; aHi = 0; aLo = 0;
    pend = 1'b0;
    heldMean = '0; heldCnt = '0; heldHi = '0; heldLo = '0;
  endtask

  // Behavioural expectation of the filtered luma for the current window
  function automatic logic [7:0] refY(input logic h);
    int s;
    int y;
    s = 0;
    for (int i = 0; i < 25; i++) s += int'(tap[i]);
    y = (s * 41) / 1024;
    if (y > 255) y = 255;
    if (!h) y = 0;
    return 8'(y);
  endfunction

  // Compare the DUT this cycle against the model, then advance the frame model
  task automatic checkOutput();
    pix_t e, got;
    logic edgeNow, expValid;
    longint m;
    e = expQ.pop_front();
    got = {post_frame_vsync, post_frame_href, post_frame_hsync, post_img_Y};
    checks++;
    assert (got === e) else begin
      failures++;
      $error("[TB] FAIL pix_path step=%0d observed=%h expected=%h", stepIdx, got, e);
    end

    edgeNow  = prevV && !e.v;
    expValid = pend && (stepIdx == deadline) && !edgeNow;
    if (expValid) begin
      if (pCnt == 0) m = 0;
      else begin
        m = pSum / pCnt;
        if (m > 255) m = 255;
      end
      heldMean = 8'(m);
      heldCnt  = 24'(pCnt);
      heldHi   = 24'(pHi);
      heldLo   = 24'(pLo);
      pend     = 1'b0;
    end
    if (edgeNow) begin
      pend = 1'b1;
      deadline = stepIdx + 33;
      pSum = aSum; pCnt = aCnt; pHi = aHi; pLo = aLo;
      lastEdge = stepIdx;
      edgeFlag = 1'b1;
    end
    if (!e.v) begin
      aSum = 0; aCnt = 0; aHi = 0; aLo = 0;
    end else if (e.h) begin
      aSum += e.y;
      aCnt++;
      if (e.y >= 8'd235) aHi++;
      if (e.y <= 8'd16)  aLo++;
    end
    prevV = e.v;

    checks++;
    assert (frame_stat_valid === expValid) else begin
      failures++;
      $error("[TB] FAIL stat_valid step=%0d observed=%b expected=%b", stepIdx, frame_stat_valid, expValid);
    end
    checks++;
    assert ({frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt} === {heldMean, heldCnt, heldHi, heldLo}) else begin
      failures++;
      $error("[TB] FAIL frame_outputs step=%0d observed=%0d/%0d/%0d/%0d expected=%0d/%0d/%0d/%0d",
             stepIdx, frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt,
             heldMean, heldCnt, heldHi, heldLo);
    end
    if (frame_stat_valid === 1'b1) begin
      validSeen = 1'b1;
      validStep = stepIdx;
      validCount++;
    end
  endtask

  // One pixel-clock cycle: drive syncs, predict output, sample at negedge
  task automatic applyStimulus(input logic v, input logic h, input logic hs);
    pix_t e;
    matrix_frame_vsync = v;
    matrix_frame_href  = h;
    matrix_frame_hsync = hs;
    e.v = v; e.h = h; e.hs = hs; e.y = refY(h);
    expQ.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    stepIdx++;
  endtask

  // Window contents: 0 = all taps val, 1 = every tap random, 2 = one random level
  task automatic setTaps(input int mode, input int val);
    int r;
    r = int'($urandom_range(0, 2047));
    for (int i = 0; i < 25; i++) begin
      if (mode == 0)      tap[i] = 11'(val);
      else if (mode == 1) tap[i] = 11'($urandom_range(0, 2047));
      else                tap[i] = 11'(r);
    end
  endtask

  // A run of active pixels on one line
  task automatic doRow(input int cols, input int mode, input int val);
    for (int c = 0; c < cols; c++) begin
      setTaps(mode, val);
      applyStimulus(1'b1, 1'b1, 1'b1);
    end
  endtask

  // A frame of rows separated by blanking; vsync is left high for the caller
  task automatic runFrame(input int rows, input int cols, input int mode, input int val);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int r = 0; r < rows; r++) begin
      doRow(cols, mode, val);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
  endtask

  // Drop vsync and idle until a valid strobe shows up, within a cycle budget
  task automatic waitValid(input int budget);
    validSeen = 1'b0;
    for (int n = 0; n < budget && !validSeen; n++) applyStimulus(1'b0, 1'b0, 1'b0);
    checks++;
    assert (validSeen === 1'b1) else begin
      failures++;
      $error("[TB] FAIL valid_timeout observed=none expected=pulse within %0d cycles", budget);
    end
  endtask

  // Synchronous reset pulse lasting one clock, model cleared to match
  task automatic doReset();
    rst = 1'b1;
    matrix_frame_vsync = 1'b0; matrix_frame_href = 1'b0; matrix_frame_hsync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelInit();
    stepIdx++;
  endtask

  // Directed sequence followed by randomized frames
  initial begin
    int vc0;
    int s0;
    checks = 0; failures = 0; stepIdx = 0; validCount = 0;
    lastEdge = 0; edgeFlag = 1'b0; validSeen = 1'b0; validStep = 0;
    rst = 1'b1;
    matrix_frame_vsync = 1'b0; matrix_frame_href = 1'b0; matrix_frame_hsync = 1'b0;
    for (int i = 0; i < 25; i++) tap[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelInit();

    $display("[TB] reset state and uniform / saturating pixels");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    runFrame(1, 0, 0, 0);
    doRow(3, 0, 100);
    doRow(2, 0, 2047);
    doRow(2, 0, 240);
    doRow(2, 0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid(60);

    $display("[TB] mixed frame 3x4");
    runFrame(0, 0, 0, 0);
    doRow(4, 0, 240);
    applyStimulus(1'b1, 1'b0, 1'b0);
    doRow(2, 0, 240);
    doRow(2, 0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    doRow(4, 0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid(60);
    checks++;
    assert (validStep - lastEdge === 33) else begin
      failures++;
      $error("[TB] FAIL mixed_latency observed=%0d expected=33", validStep - lastEdge);
    end
    checks++;
    assert ({frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt} === {8'd125, 24'd12, 24'd6, 24'd6}) else begin
      failures++;
      $error("[TB] FAIL mixed_values observed=%0d/%0d/%0d/%0d expected=125/12/6/6",
             frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt);
    end

    $display("[TB] empty frame");
    runFrame(0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid(60);
    checks++;
    assert ({frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt} === 80'd0) else begin
      failures++;
      $error("[TB] FAIL empty_values observed=%0d/%0d/%0d/%0d expected=0/0/0/0",
             frame_mean, frame_pix_cnt, frame_hi_cnt, frame_lo_cnt);
    end

    $display("[TB] reset during division");
    runFrame(2, 3, 1, 0);
    edgeFlag = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (edgeFlag && stepIdx == lastEdge + 10) break;
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    doReset();
    vc0 = validCount;
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b0);
    checks++;
    assert (validCount - vc0 === 0) else begin
      failures++;
      $error("[TB] FAIL reset_abort observed=%0d pulses expected=0", validCount - vc0);
    end
    runFrame(2, 3, 0, 100);
    waitValid(60);
    checks++;
    assert (frame_mean === 8'd100) else begin
      failures++;
      $error("[TB] FAIL post_reset_mean observed=%0d expected=100", frame_mean);
    end

    $display("[TB] back-to-back frames");
    runFrame(1, 3, 1, 0);
    s0 = stepIdx;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    doRow(4, 2, 0);
    for (int n = 0; n < 30 && stepIdx < s0 + 20; n++) applyStimulus(1'b1, 1'b0, 1'b0);
    vc0 = validCount;
    waitValid(80);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checks++;
    assert (validCount - vc0 === 1) else begin
      failures++;
      $error("[TB] FAIL b2b_pulses observed=%0d expected=1", validCount - vc0);
    end
    checks++;
    assert (validStep - lastEdge === 33) else begin
      failures++;
      $error("[TB] FAIL b2b_latency observed=%0d expected=33", validStep - lastEdge);
    end
    checks++;
    assert (frame_pix_cnt === 24'd4) else begin
      failures++;
      $error("[TB] FAIL b2b_count observed=%0d expected=4", frame_pix_cnt);
    end

    $display("[TB] random frames");
    for (int k = 0; k < 5; k++) begin
      runFrame(int'($urandom_range(1, 3)), int'($urandom_range(1, 6)), int'($urandom_range(1, 2)), 0);
      waitValid(80);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
